video_format_reporter: RTL

Sits directly downstream of the video format detector. Qualifies its raw 8-bit BVM format code over several consecutive frames and publishes only stable codes to the monitor-facing register. Signals each published change to the host side with a level req/ack handshake, and forces "no signal" (0x00) when frame markers stop arriving.

---
 rtl/video_format_reporter_if.sv | 25 ++
 rtl/video_format_reporter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/video_format_reporter_if.sv
// Host-facing side of the format reporter: published code,
// change counter and the level req/ack change handshake.
interface video_format_reporter_if;
    logic [7:0] format_out;
    logic       format_valid;
    logic       change_req;
    logic [7:0] change_count;
    logic       change_ack;

    modport master (
        output format_out,
        output format_valid,
        output change_req,
        output change_count,
        input  change_ack
    );

    modport slave (
        input  format_out,
        input  format_valid,
        input  change_req,
        input  change_count,
        output change_ack
    );
endinterface

// File: rtl/video_format_reporter.sv
// Qualifies the detector's raw format code over several frames and
// publishes stable codes; forces 0x00 when vsync stops arriving.
module video_format_reporter #(
    parameter int unsigned STABLE_FRAMES = 4,
    parameter int unsigned LOSS_TIMEOUT  = 2500000
) (
    input  logic       clk,
    input  logic       reset_x,
    input  logic       vsync_in,
    input  logic [7:0] format_in,
    video_format_reporter_if.master host
);

    localparam int unsigned LW = $clog2(LOSS_TIMEOUT + 1);
    localparam logic [LW-1:0] LOSS_MAX  = LW'(LOSS_TIMEOUT);
    localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_TIMEOUT - 1);
    localparam logic [7:0]    STABLE_N  = 8'(STABLE_FRAMES);

    typedef enum logic [1:0] {
        S_NO_SIGNAL,
        S_QUALIFY,
        S_LOCKED
    } state_t;

    logic          r_vs_s1;
    logic          r_vs_s2;
    logic          r_vs_d;
    logic [7:0]    r_fmt_s1;
    logic [7:0]    r_fmt_s2;
    logic [7:0]    r_cand;
    logic [7:0]    r_stable;
    logic [LW-1:0] r_loss_cnt;
    state_t        r_state;
    logic [7:0]    r_fmt_out;
    logic          r_valid;
    logic          r_req;
    logic [7:0]    r_count;

    logic          w_tick;
    logic          w_loss;
    logic [7:0]    w_stable_tick;
    logic          w_qual;
    state_t        w_state_nxt;
    logic          w_publish;
    logic [7:0]    w_pub_code;

    // Format bits share the vsync sync depth, so the code seen at
    // frame_tick already reflects the frame that just started.
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            r_vs_s1  <= 1'b0;
            r_vs_s2  <= 1'b0;
            r_vs_d   <= 1'b0;
            r_fmt_s1 <= 8'h00;
            r_fmt_s2 <= 8'h00;
        end else begin
            r_vs_s1  <= vsync_in;
            r_vs_s2  <= r_vs_s1;
            r_vs_d   <= r_vs_s2;
            r_fmt_s1 <= format_in;
            r_fmt_s2 <= r_fmt_s1;
        end
    end

    assign w_tick = r_vs_d & ~r_vs_s2;

    // Firing on the step into LOSS_TIMEOUT makes loss a one-shot.
    assign w_loss = ~w_tick & (r_loss_cnt == LOSS_LAST);

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            r_loss_cnt <= '0;
        end else if (w_tick) begin
            r_loss_cnt <= '0;
        end else if (r_loss_cnt != LOSS_MAX) begin
            r_loss_cnt <= r_loss_cnt + 1'b1;
        end
    end

    always_comb begin
        w_stable_tick = 8'd1;
        if (r_fmt_s2 == r_cand) begin
            if (r_stable == 8'hFF) w_stable_tick = r_stable;
            else                   w_stable_tick = r_stable + 8'd1;
        end
    end

    assign w_qual = (w_stable_tick >= STABLE_N);

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            r_cand   <= 8'h00;
            r_stable <= 8'h00;
        end else if (w_loss) begin
            r_cand   <= 8'h00;
            r_stable <= 8'h00;
        end else if (w_tick) begin
            r_cand   <= r_fmt_s2;
            r_stable <= w_stable_tick;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_publish   = 1'b0;
        w_pub_code  = r_fmt_s2;
        if (w_loss) begin
            w_state_nxt = S_NO_SIGNAL;
            w_publish   = (r_fmt_out != 8'h00);
            w_pub_code  = 8'h00;
        end else if (w_tick) begin
            unique case (r_state)
                S_NO_SIGNAL: begin
                    w_state_nxt = S_QUALIFY;
                end
                S_QUALIFY: begin
                    if (r_fmt_s2 == r_fmt_out) begin
                        w_state_nxt = S_LOCKED;
                    end else if (w_qual) begin
                        w_state_nxt = S_LOCKED;
                        w_publish   = 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (r_fmt_s2 != r_fmt_out) begin
                        if (w_qual) w_publish   = 1'b1;
                        else        w_state_nxt = S_QUALIFY;
                    end
                end
                default: begin
                    w_state_nxt = S_NO_SIGNAL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) r_state <= S_NO_SIGNAL;
        else          r_state <= w_state_nxt;
    end

    // A publish on the ack cycle keeps req high: the host must see it.
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            r_fmt_out <= 8'h00;
            r_valid   <= 1'b0;
            r_req     <= 1'b0;
            r_count   <= 8'h00;
        end else if (w_publish) begin
            r_fmt_out <= w_pub_code;
            r_valid   <= (w_pub_code != 8'h00);
            r_req     <= 1'b1;
            r_count   <= r_count + 8'd1;
        end else if (r_req && host.change_ack) begin
            r_req     <= 1'b0;
        end
    end

    assign host.format_out   = r_fmt_out;
    assign host.format_valid = r_valid;
    assign host.change_req   = r_req;
    assign host.change_count = r_count;

endmodule
